sd_cmd_ctrl_fsm: RTL

Sequencing controller for the SD CMD line. It accepts a command-issue request and drives the command state and bit counters that the CMD send and receive shift registers consume. It walks the SEND, WAIT (Ncr), RECEIVE and FINISH (Ncc) phases, then reports done, timeout and CRC status to the host-side register block. It sits between the SD host register interface and the CMD send/receive shift registers, all in the in_sd_clk domain.

---
 rtl/sd_cmd_ctrl_fsm_if.sv | 55 +++++
 rtl/sd_cmd_ctrl_fsm.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_ctrl_fsm_if.sv
// Host-side and shift-register-side signal bundle for the SD CMD sequencing controller.
// Carries out_end_bit_error only when SD_CMD_END_BIT_CHECK_EN is defined.
interface sd_cmd_ctrl_fsm_if;
    logic       in_cmd_start;
    logic [1:0] in_response_type;
    logic       in_serial_cmd;
    logic       in_cmd_receive_crc_error;
    logic [2:0] out_current_state;
    logic [5:0] out_has_send_bit;
    logic [7:0] out_has_receive_bit;
    logic       out_long_response;
    logic       out_cmd_busy;
    logic       out_cmd_done;
    logic       out_timeout_error;
    logic       out_crc_error;
`ifdef SD_CMD_END_BIT_CHECK_EN
    logic       out_end_bit_error;
`endif

    modport master (
`ifdef SD_CMD_END_BIT_CHECK_EN
        input  out_end_bit_error,
`endif
        output in_cmd_start,
        output in_response_type,
        output in_serial_cmd,
        output in_cmd_receive_crc_error,
        input  out_current_state,
        input  out_has_send_bit,
        input  out_has_receive_bit,
        input  out_long_response,
        input  out_cmd_busy,
        input  out_cmd_done,
        input  out_timeout_error,
        input  out_crc_error
    );

    modport slave (
`ifdef SD_CMD_END_BIT_CHECK_EN
        output out_end_bit_error,
`endif
        input  in_cmd_start,
        input  in_response_type,
        input  in_serial_cmd,
        input  in_cmd_receive_crc_error,
        output out_current_state,
        output out_has_send_bit,
        output out_has_receive_bit,
        output out_long_response,
        output out_cmd_busy,
        output out_cmd_done,
        output out_timeout_error,
        output out_crc_error
    );
endinterface

// File: rtl/sd_cmd_ctrl_fsm.sv
// SD CMD line sequencer: SEND -> WAIT (Ncr) -> RECEIVE -> FINISH (Ncc), with done/timeout/CRC status.
// Optional end-bit check enabled by defining SD_CMD_END_BIT_CHECK_EN.
module sd_cmd_ctrl_fsm #(
    parameter int unsigned RESP_TIMEOUT = 64,
    parameter int unsigned NCC_CYCLES   = 8,
    parameter int unsigned CMD_BITS     = 48
) (
    input  logic               in_sd_clk,
    input  logic               hrst,
    input  logic               in_soft_reset,
    sd_cmd_ctrl_fsm_if.slave   sd
);
    localparam int unsigned SEND_W = 6;
    localparam int unsigned RECV_W = 8;
    localparam int unsigned WAIT_W = 8;
    localparam int unsigned NCC_W  = 4;

    localparam logic [SEND_W-1:0] SEND_LAST       = SEND_W'(CMD_BITS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST       = WAIT_W'(RESP_TIMEOUT - 1);
    localparam logic [NCC_W-1:0]  NCC_LAST        = NCC_W'(NCC_CYCLES - 1);
    localparam logic [RECV_W-1:0] RECV_SHORT_LAST = RECV_W'(46);
    localparam logic [RECV_W-1:0] RECV_LONG_LAST  = RECV_W'(134);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RECEIVE = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [SEND_W-1:0]  send_cnt_q, send_cnt_d;
    logic [RECV_W-1:0]  recv_cnt_q, recv_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [NCC_W-1:0]   ncc_cnt_q, ncc_cnt_d;
    logic [1:0]         resp_type_q, resp_type_d;
    logic               long_q, long_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               crc_q, crc_d;
    logic               end_bit_q, end_bit_d;
    logic               sync_rst;
    logic               has_resp;
    logic [RECV_W-1:0]  recv_last;

    assign sync_rst  = hrst | ~in_soft_reset;
    assign has_resp  = (resp_type_q != 2'b00);
    assign recv_last = long_q ? RECV_LONG_LAST : RECV_SHORT_LAST;

    // State, counters and registered outputs.
    always_ff @(posedge in_sd_clk) begin
        if (sync_rst) begin
            state_q     <= ST_IDLE;
            send_cnt_q  <= '0;
            recv_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            ncc_cnt_q   <= '0;
            resp_type_q <= '0;
            long_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            crc_q       <= 1'b0;
            end_bit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            send_cnt_q  <= send_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            ncc_cnt_q   <= ncc_cnt_d;
            resp_type_q <= resp_type_d;
            long_q      <= long_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            crc_q       <= crc_d;
            end_bit_q   <= end_bit_d;
        end
    end

    // Next-state and next-output logic; each counter is zeroed on entry to its own state.
    always_comb begin
        state_d     = state_q;
        send_cnt_d  = send_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        ncc_cnt_d   = ncc_cnt_q;
        resp_type_d = resp_type_q;
        long_d      = long_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        crc_d       = crc_q;
        end_bit_d   = end_bit_q;

        case (state_q)
            ST_IDLE: begin
                if (sd.in_cmd_start) begin
                    state_d     = ST_SEND;
                    resp_type_d = sd.in_response_type;
                    long_d      = (sd.in_response_type == 2'b10);
                    send_cnt_d  = '0;
                    timeout_d   = 1'b0;
                    crc_d       = 1'b0;
                    end_bit_d   = 1'b0;
                end
            end
            ST_SEND: begin
                if (send_cnt_q == SEND_LAST) begin
                    if (has_resp) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = '0;
                    end else begin
                        state_d   = ST_FINISH;
                        ncc_cnt_d = '0;
                    end
                end else begin
                    send_cnt_d = send_cnt_q + SEND_W'(1);
                end
            end
            ST_WAIT: begin
                // A start bit on the limit cycle takes priority over the timeout.
                if (!sd.in_serial_cmd) begin
                    state_d    = ST_RECEIVE;
                    recv_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = ST_FINISH;
                    ncc_cnt_d = '0;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_RECEIVE: begin
                if (recv_cnt_q == recv_last) begin
                    state_d   = ST_FINISH;
                    ncc_cnt_d = '0;
                    if (!sd.in_serial_cmd) begin
                        end_bit_d = 1'b1;
                    end
                end else begin
                    recv_cnt_d = recv_cnt_q + RECV_W'(1);
                end
            end
            ST_FINISH: begin
                // Receive block's CRC compare is valid on the first Ncc cycle.
                if ((ncc_cnt_q == '0) && has_resp && !timeout_q) begin
                    crc_d = sd.in_cmd_receive_crc_error;
                end
                if (ncc_cnt_q == NCC_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    ncc_cnt_d = ncc_cnt_q + NCC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign sd.out_current_state   = state_q;
    assign sd.out_has_send_bit    = send_cnt_q;
    assign sd.out_has_receive_bit = recv_cnt_q;
    assign sd.out_long_response   = long_q;
    assign sd.out_cmd_busy        = busy_q;
    assign sd.out_cmd_done        = done_q;
    assign sd.out_timeout_error   = timeout_q;
    assign sd.out_crc_error       = crc_q;

`ifdef SD_CMD_END_BIT_CHECK_EN
    assign sd.out_end_bit_error   = end_bit_q;
`else
    logic unused_end_bit;
    assign unused_end_bit = end_bit_q;
`endif

endmodule
